// File: rtl/ws2812b_defs.sv
// Timing constants, word width and receiver state encoding shared by the
// WS2812B transmit and receive paths so both ends agree on the 100 MHz timing.
package ws2812b_defs;

  localparam int unsigned DEF_THRESH       = 60;
  localparam int unsigned DEF_MIN_HIGH     = 15;
  localparam int unsigned DEF_MAX_HIGH     = 150;
  localparam int unsigned DEF_RESET_CYCLES = 28000;
  localparam int unsigned DEF_CW           = 15;

  localparam int unsigned GRB_W     = 24;
  localparam int unsigned BIT_CNT_W = 5;

  typedef enum logic [2:0] {
    SIDLE = 3'd0,
    SHIGH = 3'd1,
    SLOW  = 3'd2,
    SPASS = 3'd3,
    SERR  = 3'd4
  } rxState_t;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grbWord_t;

endpackage

// File: rtl/ws2812b_pulse_timer.sv
// DIN synchroniser, edge detect and saturating high/low run-length counters.
module ws2812b_pulse_timer
  import ws2812b_defs::*;
#(
  parameter int unsigned CW     = DEF_CW,
  parameter int unsigned HI_SAT = DEF_MAX_HIGH,
  parameter int unsigned LO_SAT = DEF_RESET_CYCLES
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          din,
  output logic          dinS,
  output logic          rise_c,
  output logic          fall_c,
  output logic [CW-1:0] hiCnt,
  output logic [CW-1:0] loCnt
);

  logic syncA;
  logic syncB;
  logic dinPrev;

  // hiCnt is the length of the current/just-ended high run; loCnt the low run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      syncA   <= 1'b0;
      syncB   <= 1'b0;
      dinPrev <= 1'b0;
      hiCnt   <= '0;
      loCnt   <= '0;
    end else begin
      syncA   <= din;
      syncB   <= syncA;
      dinPrev <= syncB;
      if (syncB) begin
        loCnt <= '0;
        if (!dinPrev) begin
          hiCnt <= CW'(1);
        end else if (hiCnt < CW'(HI_SAT)) begin
          hiCnt <= hiCnt + CW'(1);
        end
      end else if (loCnt < CW'(LO_SAT)) begin
        loCnt <= loCnt + CW'(1);
      end
    end
  end

  assign dinS   = syncB;
  assign rise_c = syncB & ~dinPrev;
  assign fall_c = ~syncB & dinPrev;

endmodule

// File: rtl/ws2812b_pixel_rx.sv
// Single WS2812B pixel receiver: decodes the first 24 NZR bits into a GRB word,
// forwards the rest of the frame on DOUT and flags the reset code.
module ws2812b_pixel_rx
  import ws2812b_defs::*;
#(
  parameter int unsigned THRESH       = DEF_THRESH,
  parameter int unsigned MIN_HIGH     = DEF_MIN_HIGH,
  parameter int unsigned MAX_HIGH     = DEF_MAX_HIGH,
  parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int unsigned CW           = DEF_CW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             DIN,
  output logic             DOUT,
  output logic [GRB_W-1:0] grb,
  output logic             pixValid,
  output logic             resetSeen,
  output logic             protoErr
);

  logic          dinS;
  logic          rise_c;
  logic          fall_c;
  logic [CW-1:0] hiCnt;
  logic [CW-1:0] loCnt;

  ws2812b_pulse_timer #(
    .CW     (CW),
    .HI_SAT (MAX_HIGH),
    .LO_SAT (RESET_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .din    (DIN),
    .dinS   (dinS),
    .rise_c (rise_c),
    .fall_c (fall_c),
    .hiCnt  (hiCnt),
    .loCnt  (loCnt)
  );

  rxState_t             state;
  logic [BIT_CNT_W-1:0] bitCnt;
  logic [GRB_W-2:0]     sh;
  grbWord_t             grbReg;
  logic                 pixValidReg;
  logic                 resetSeenReg;
  logic                 protoErrReg;
  logic                 passing;

  logic             newBit;
  logic [GRB_W-1:0] shNext;
  logic             loDone;
  logic             hiGlitch;
  logic             hiTooLong;

  // The 24th bit is never stored in sh; it is appended straight into grb.
  assign newBit    = (hiCnt >= CW'(THRESH));
  assign shNext    = {sh, newBit};
  assign loDone    = (loCnt >= CW'(RESET_CYCLES));
  assign hiGlitch  = (hiCnt < CW'(MIN_HIGH));
  assign hiTooLong = (hiCnt >= CW'(MAX_HIGH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= SIDLE;
      bitCnt       <= '0;
      sh           <= '0;
      grbReg       <= '0;
      pixValidReg  <= 1'b0;
      resetSeenReg <= 1'b0;
      protoErrReg  <= 1'b0;
      passing      <= 1'b0;
    end else begin
      pixValidReg  <= 1'b0;
      resetSeenReg <= 1'b0;
      // Error stays visible during the resetSeen strobe, then clears.
      if (resetSeenReg) begin
        protoErrReg <= 1'b0;
      end

      case (state)
        SIDLE: begin
          bitCnt  <= '0;
          passing <= 1'b0;
          if (rise_c) begin
            state <= SHIGH;
          end
        end

        SHIGH: begin
          if (hiTooLong) begin
            protoErrReg <= 1'b1;
            state       <= SERR;
          end else if (fall_c) begin
            if (hiGlitch) begin
              state <= (bitCnt != '0) ? SLOW : SIDLE;
            end else if (bitCnt == BIT_CNT_W'(GRB_W - 1)) begin
              grbReg      <= shNext;
              pixValidReg <= 1'b1;
              passing     <= 1'b1;
              sh          <= '0;
              bitCnt      <= '0;
              state       <= SPASS;
            end else begin
              sh     <= shNext[GRB_W-2:0];
              bitCnt <= bitCnt + BIT_CNT_W'(1);
              state  <= SLOW;
            end
          end
        end

        SLOW: begin
          if (rise_c) begin
            state <= SHIGH;
          end else if (loDone) begin
            // Reset code inside a partial word: drop it and flag the error.
            protoErrReg  <= 1'b1;
            resetSeenReg <= 1'b1;
            sh           <= '0;
            bitCnt       <= '0;
            state        <= SIDLE;
          end
        end

        SPASS: begin
          if (loDone) begin
            resetSeenReg <= 1'b1;
            passing      <= 1'b0;
            state        <= SIDLE;
          end
        end

        SERR: begin
          passing <= 1'b0;
          if (loDone) begin
            resetSeenReg <= 1'b1;
            bitCnt       <= '0;
            sh           <= '0;
            state        <= SIDLE;
          end
        end

        default: begin
          state <= SIDLE;
        end
      endcase
    end
  end

  // Both terms are flops, so forwarding adds no latency beyond the synchroniser.
  assign DOUT      = passing & dinS;
  assign grb       = grbReg;
  assign pixValid  = pixValidReg;
  assign resetSeen = resetSeenReg;
  assign protoErr  = protoErrReg;

endmodule

// File: tb/tb_ws2812b_pixel_rx.sv
// Self-checking bench for ws2812b_pixel_rx: table of plain/glitched words plus
// hand sequences for chaining, partial words, over-long highs and mid-word reset.
`timescale 1ns/1ps
module tb_ws2812b_pixel_rx;

  localparam int unsigned P_THRESH = 60;
  localparam int unsigned P_MIN    = 15;
  localparam int unsigned P_MAX    = 150;
  localparam int unsigned P_RST    = 200;
  localparam int unsigned P_CW     = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        DIN = 1'b0;
  logic        DOUT;
  logic [23:0] grb;
  logic        pixValid;
  logic        resetSeen;
  logic        protoErr;

  always #5 clk = ~clk;

  ws2812b_pixel_rx #(
    .THRESH       (P_THRESH),
    .MIN_HIGH     (P_MIN),
    .MAX_HIGH     (P_MAX),
    .RESET_CYCLES (P_RST),
    .CW           (P_CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .DIN       (DIN),
    .DOUT      (DOUT),
    .grb       (grb),
    .pixValid  (pixValid),
    .resetSeen (resetSeen),
    .protoErr  (protoErr)
  );

  int          checks = 0;
  int          errors = 0;
  logic [23:0] expQ[$];
  int          cyc = 0;
  int          pixSeen = 0;
  int          rstCnt = 0;
  int          lastRstCyc = 0;
  int          lastFallCyc = 0;
  logic        errAtRst = 1'b0;
  bit          doutWatch = 1'b0;
  bit          doutSeen = 1'b0;
  bit          passCheck = 1'b0;
  logic [1:0]  dinHist = 2'b00;

  typedef struct {
    logic [23:0] word;
    bit          glitch;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard/monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (pixValid) begin
      pixSeen++;
      if (expQ.size() == 0) begin
        check("pixValid_unexpected", 32'(pixValid), 32'd0);
      end else begin
        check("sb_grb", 32'(grb), 32'(expQ.pop_front()));
      end
      if (resetSeen) check("strobe_overlap", 32'(resetSeen), 32'd0);
    end
    if (resetSeen) begin
      rstCnt++;
      lastRstCyc = cyc;
      errAtRst   = protoErr;
    end
    if (doutWatch && DOUT) doutSeen = 1'b1;
    if (passCheck) check("dout_fwd", 32'(DOUT), 32'(dinHist[1]));
    dinHist = {dinHist[0], DIN};
  end

  task automatic hold(input logic v, input int n);
    DIN = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendBit(input logic b, input bit glitch);
    int lo;
    lo = b ? 45 : 85;
    hold(1'b1, b ? 80 : 40);
    lastFallCyc = cyc;
    if (glitch) begin
      hold(1'b0, 20);
      hold(1'b1, 5);
      hold(1'b0, lo - 25);
    end else begin
      hold(1'b0, lo);
    end
  endtask

  task automatic sendWord(input logic [23:0] w, input bit glitch);
    for (int i = 23; i >= 0; i--) sendBit(w[i], glitch && (i != 0));
  endtask

  initial begin
    int pB;
    int rB;
    int fallCyc;

    vecs[0] = '{24'h00FF00, 1'b0};
    vecs[1] = '{24'hA5A5A5, 1'b1};
    vecs[2] = '{24'hFFFFFF, 1'b0};
    vecs[3] = '{24'h000001, 1'b1};

    reset = 1'b0;
    DIN   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grb", 32'(grb), 32'd0);
    check("rst_pixValid", 32'(pixValid), 32'd0);
    check("rst_resetSeen", 32'(resetSeen), 32'd0);
    check("rst_protoErr", 32'(protoErr), 32'd0);
    check("rst_dout", 32'(DOUT), 32'd0);
    reset = 1'b1;
    hold(1'b0, 5);

    // Table: each word decodes, DOUT stays quiet, then a clean reset code.
    for (int v = 0; v < 4; v++) begin
      pB = pixSeen;
      rB = rstCnt;
      expQ.push_back(vecs[v].word);
      doutSeen  = 1'b0;
      doutWatch = 1'b1;
      sendWord(vecs[v].word, vecs[v].glitch);
      doutWatch = 1'b0;
      check("tbl_dout_quiet", 32'(doutSeen), 32'd0);
      check("tbl_protoErr", 32'(protoErr), 32'd0);
      check("tbl_pix_count", 32'(pixSeen - pB), 32'd1);
      check("tbl_grb", 32'(grb), 32'(vecs[v].word));
      hold(1'b0, 250);
      check("tbl_reset_count", 32'(rstCnt - rB), 32'd1);
      check("tbl_err_at_reset", 32'(errAtRst), 32'd0);
    end

    // Two words: first captured, second forwarded with 2-cycle latency.
    pB = pixSeen;
    rB = rstCnt;
    expQ.push_back(24'h123456);
    sendWord(24'h123456, 1'b0);
    passCheck = 1'b1;
    sendWord(24'hABCDEF, 1'b0);
    passCheck = 1'b0;
    fallCyc = lastFallCyc;
    hold(1'b0, 250);
    check("chain_pix_count", 32'(pixSeen - pB), 32'd1);
    check("chain_grb", 32'(grb), 32'h123456);
    check("chain_reset_count", 32'(rstCnt - rB), 32'd1);
    // 2 synchroniser flops + registered strobe after RESET_CYCLES low counts.
    check("chain_reset_delay", 32'(lastRstCyc - fallCyc), 32'(P_RST + 3));

    // Partial word (10 bits) followed by reset code.
    pB = pixSeen;
    rB = rstCnt;
    for (int i = 0; i < 10; i++) sendBit(logic'(i % 2), 1'b0);
    hold(1'b0, 250);
    check("partial_reset_count", 32'(rstCnt - rB), 32'd1);
    check("partial_err_on_strobe", 32'(errAtRst), 32'd1);
    check("partial_err_cleared", 32'(protoErr), 32'd0);
    check("partial_pix_count", 32'(pixSeen - pB), 32'd0);
    check("partial_grb_kept", 32'(grb), 32'h123456);

    // Over-long high: error exactly at MAX_HIGH, cleared by the reset code.
    rB = rstCnt;
    hold(1'b1, 2 + P_MAX);
    check("maxhi_before", 32'(protoErr), 32'd0);
    hold(1'b1, 1);
    check("maxhi_at", 32'(protoErr), 32'd1);
    hold(1'b1, 200 - 3 - P_MAX);
    hold(1'b0, 250);
    check("maxhi_reset_count", 32'(rstCnt - rB), 32'd1);
    check("maxhi_err_on_strobe", 32'(errAtRst), 32'd1);
    check("maxhi_err_cleared", 32'(protoErr), 32'd0);
    pB = pixSeen;
    expQ.push_back(24'h0F0F0F);
    sendWord(24'h0F0F0F, 1'b0);
    hold(1'b0, 250);
    check("maxhi_next_grb", 32'(grb), 32'h0F0F0F);
    check("maxhi_next_pix", 32'(pixSeen - pB), 32'd1);

    // Async reset mid-word, then a fresh word.
    pB = pixSeen;
    rB = rstCnt;
    for (int i = 0; i < 12; i++) sendBit(logic'(i % 2 == 0), 1'b0);
    hold(1'b1, 30);
    reset = 1'b0;
    hold(1'b0, 10);
    check("midrst_grb", 32'(grb), 32'd0);
    check("midrst_protoErr", 32'(protoErr), 32'd0);
    reset = 1'b1;
    hold(1'b0, 250);
    check("midrst_no_pix", 32'(pixSeen - pB), 32'd0);
    check("midrst_no_reset", 32'(rstCnt - rB), 32'd0);
    expQ.push_back(24'h112233);
    sendWord(24'h112233, 1'b0);
    hold(1'b0, 250);
    check("midrst_grb_after", 32'(grb), 32'h112233);
    check("midrst_pix_after", 32'(pixSeen - pB), 32'd1);
    check("midrst_reset_after", 32'(rstCnt - rB), 32'd1);

    check("sb_queue_empty", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
